// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared SPI slave types (mode struct, FSM state) and shift-edge selection helpers.
package spi_slave_pkg;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam logic EDGE_LEAD  = 1'b0;
  localparam logic EDGE_TRAIL = 1'b1;
  function automatic logic shift_edge(input spi_mode_t m);
    return m.cpha ? EDGE_LEAD : EDGE_TRAIL;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous pin with rise/fall pulses on the synchronised level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] s;
  logic p;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      p <= 1'b0;
    end else begin
      s <= {s[STAGES-2:0], d};
      p <= s[STAGES-1];
    end
  assign rise = s[STAGES-1] & ~p;
  assign fall = ~s[STAGES-1] & p;
endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: clk-oversampled SPI slave, runtime mode 0-3, back-to-back WIDTH-bit words.
// Define SPI_SLAVE_LSB_FIRST_EN to add the lsb_first input (latched per frame).
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_IDLE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpol,
  input  logic             cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic             lsb_first,
`endif
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_first,
  output logic             busy,
  output logic             tx_underrun,
  output logic             frame_done,
  output logic             rx_partial
);
  localparam int CW = $clog2(WIDTH);
  function automatic logic head(input logic [WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[WIDTH-1];
  endfunction
  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w, input logic lsb);
    return lsb ? w >> 1 : w << 1;
  endfunction
  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_q;
  logic [SYNC_STAGES-1:0] mosi_s;
  state_t state_q, state_d;
  spi_mode_t mode_q;
  logic lsb_q;
  logic [WIDTH-1:0] hold_q, tx_sh, rx_sh, new_word, tx_src, rx_nxt;
  logic [CW-1:0] cnt;
  logic first_q, load_pend;
  logic lead, trail, in_shift, shf_lead, smp, shf, start, stop, take, word_end;
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst_n(rst_n), .d(sck), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .rise(cs_rise), .fall(cs_fall)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mosi_s <= '0;
    else mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
  assign mosi_q = mosi_s[SYNC_STAGES-1];
`ifdef SPI_SLAVE_LSB_FIRST_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lsb_q <= 1'b0;
    else if (start) lsb_q <= lsb_first;
`else
  assign lsb_q = 1'b0;
`endif
  // cs sync resets low so a cs_n already low at reset release is not taken as a fresh fall
  assign start    = (state_q == IDLE) & cs_fall;
  assign stop     = (state_q != IDLE) & cs_rise;
  assign busy     = state_q != IDLE;
  assign miso_oe  = state_q != IDLE;
  assign lead     = mode_q.cpol ? sck_fall : sck_rise;
  assign trail    = mode_q.cpol ? sck_rise : sck_fall;
  assign in_shift = (state_q == SHIFT) & ~cs_rise;
  assign shf_lead = shift_edge(mode_q) == EDGE_LEAD;
  assign shf      = in_shift & (shf_lead ? lead : trail);
  assign smp      = in_shift & (shf_lead ? trail : lead);
  assign word_end = smp & (cnt == CW'(WIDTH - 1));
  assign take     = start | (shf & load_pend);
  assign new_word = tx_ready ? TX_IDLE : hold_q;
  assign tx_src   = load_pend ? new_word : (mode_q.cpha ? tx_sh : adv(tx_sh, lsb_q));
  assign rx_nxt   = lsb_q ? {mosi_q, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], mosi_q};
  always_comb begin
    state_d = stop ? IDLE : start ? LOAD : (state_q == LOAD) ? SHIFT : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      miso        <= 1'b0;
      tx_ready    <= 1'b1;
      hold_q      <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_done  <= 1'b0;
      rx_partial  <= 1'b0;
      cnt         <= '0;
      first_q     <= 1'b0;
      load_pend   <= 1'b0;
      mode_q      <= '0;
    end else begin
      rx_valid    <= word_end;
      rx_first    <= word_end & first_q;
      tx_underrun <= take & tx_ready;
      frame_done  <= stop;
      rx_partial  <= stop & (cnt != '0);
      if (tx_valid && tx_ready) begin
        hold_q   <= tx_data;
        tx_ready <= 1'b0;
      end else if (take) tx_ready <= 1'b1;
      if (stop) begin
        cnt       <= '0;
        load_pend <= 1'b0;
      end else if (start) begin
        mode_q    <= {cpol, cpha};
        tx_sh     <= new_word;
        first_q   <= 1'b1;
        cnt       <= '0;
        load_pend <= 1'b0;
      end else begin
        if (state_q == LOAD && !mode_q.cpha) miso <= head(tx_sh, lsb_q);
        if (smp) begin
          rx_sh <= rx_nxt;
          cnt   <= word_end ? '0 : cnt + CW'(1);
        end
        if (word_end) begin
          rx_data   <= rx_nxt;
          first_q   <= 1'b0;
          load_pend <= 1'b1;
        end
        // cpha=0 keeps the bit on the wire at the head; cpha=1 drives the head then advances
        if (shf) begin
          tx_sh     <= mode_q.cpha ? adv(tx_src, lsb_q) : tx_src;
          miso      <= head(tx_src, lsb_q);
          load_pend <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI master exchanges against spi_slave_sync with hand-computed expectations.
module tb_spi_slave_sync;
  localparam int HALF = 80;
  logic clk = 1'b0, rst_n = 1'b1, cpol = 1'b0, cpha = 1'b0;
  logic sck = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic miso, miso_oe, tx_ready, rx_valid, rx_first, busy, tx_underrun, frame_done, rx_partial;
  logic [7:0] rx_data;
  int vecs = 0, errs = 0;
  int n_rxv = 0, n_first = 0, n_fd = 0, n_part = 0, n_undr = 0;
  logic [7:0] rx_log[$];
  spi_slave_sync #(.WIDTH(8), .SYNC_STAGES(2), .TX_IDLE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first), .busy(busy),
    .tx_underrun(tx_underrun), .frame_done(frame_done), .rx_partial(rx_partial)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      rx_log.push_back(rx_data);
      if (rx_first) n_first++;
    end
    if (frame_done) begin
      n_fd++;
      if (rx_partial) n_part++;
    end
    if (tx_underrun) n_undr++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk);
    check("push_rdy", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic xfer(input int nbits, input logic [23:0] tws, output logic [23:0] rws);
    rws = '0;
    for (int i = nbits - 1; i >= 0; i--)
      if (!cpha) begin
        mosi = tws[i];
        #HALF sck = ~cpol;
        rws[i] = miso;
        #HALF sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = tws[i];
        #HALF sck = cpol;
        rws[i] = miso;
        #HALF;
      end
  endtask
  task automatic frame(input logic pol, input logic pha, input logic [23:0] tws, input int nbits,
                       output logic [23:0] rws);
    cpol = pol;
    cpha = pha;
    sck = pol;
    #HALF cs_n = 1'b0;
    #HALF check("busy_oe", {30'd0, busy, miso_oe}, 32'd3);
    xfer(nbits, tws, rws);
    #HALF cs_n = 1'b1;
    #(2 * HALF);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int s_rxv, s_first, s_fd, s_part, s_undr;
    logic [23:0] rw;
    #10 rst_n = 1'b0;
    #30 check("reset_ctl", {miso, miso_oe, tx_ready, busy, rx_valid, rx_first, frame_done, rx_partial, tx_underrun}, 32'h040);
    check("reset_rx", rx_data, 8'h00);
    #20 rst_n = 1'b1;
    #100;
    for (int m = 0; m < 4; m++) begin
      push(8'hA5);
      check("hold_full", tx_ready, 1'b0);
      s_rxv = n_rxv; s_first = n_first; s_fd = n_fd; s_part = n_part;
      frame(m[1], m[0], 24'h3C, 8, rw);
      check($sformatf("miso_m%0d", m), rw[7:0], 8'hA5);
      check($sformatf("rx_m%0d", m), rx_data, 8'h3C);
      check($sformatf("rxv_m%0d", m), n_rxv - s_rxv, 1);
      check($sformatf("first_m%0d", m), n_first - s_first, 1);
      check($sformatf("done_m%0d", m), n_fd - s_fd, 1);
      check($sformatf("part_m%0d", m), n_part - s_part, 0);
    end
    push(8'h11);
    check("hold_full3", tx_ready, 1'b0);
    s_rxv = n_rxv; s_first = n_first; s_undr = n_undr;
    fork
      push(8'h22);
      frame(1'b0, 1'b1, 24'h010203, 24, rw);
    join
    check("miso_3w", rw, 24'h112200);
    check("undr_3w", n_undr - s_undr, 1);
    check("rxv_3w", n_rxv - s_rxv, 3);
    check("first_3w", n_first - s_first, 1);
    check("rx_3w", {rx_log[rx_log.size()-3], rx_log[rx_log.size()-2], rx_log[rx_log.size()-1]}, 24'h010203);
    s_rxv = n_rxv; s_fd = n_fd; s_part = n_part;
    frame(1'b0, 1'b0, 24'h15, 5, rw);
    check("rxv_part", n_rxv - s_rxv, 0);
    check("done_part", n_fd - s_fd, 1);
    check("part_flag", n_part - s_part, 1);
    push(8'h5A);
    s_rxv = n_rxv;
    frame(1'b0, 1'b0, 24'hC3, 8, rw);
    check("miso_after", rw[7:0], 8'h5A);
    check("rx_after", rx_data, 8'hC3);
    check("rxv_after", n_rxv - s_rxv, 1);
    push(8'h77);
    cpol = 1'b0;
    cpha = 1'b0;
    sck = 1'b0;
    #HALF cs_n = 1'b0;
    #HALF xfer(3, 24'h5, rw);
    #40 rst_n = 1'b0;
    #1 check("rst_mid_ctl", {miso, miso_oe, tx_ready, busy, rx_valid, rx_first, frame_done, rx_partial, tx_underrun}, 32'h040);
    check("rst_mid_rx", rx_data, 8'h00);
    #(HALF - 1) rst_n = 1'b1;
    #(4 * HALF) check("no_resume", busy, 1'b0);
    cs_n = 1'b1;
    #(2 * HALF);
    push(8'h96);
    s_rxv = n_rxv; s_first = n_first;
    frame(1'b0, 1'b0, 24'h69, 8, rw);
    check("miso_rst", rw[7:0], 8'h96);
    check("rx_rst", rx_data, 8'h69);
    check("first_rst", n_first - s_first, 1);
    check("rxv_rst", n_rxv - s_rxv, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
